// File: rtl/xbus_arbiter_pkg.sv
// Shared definitions for the two-master internal data bus arbiter.
// Widths default to the picoVersat bus; FSM encodings are fixed for legacy tools.
package xbus_arbiter_pkg;

    localparam int XBUS_ADDR_W   = 13;
    localparam int XBUS_DATA_W   = 32;
    localparam int XBUS_LOCK_MAX = 16;

    localparam logic [1:0] XBUS_IDLE = 2'd0;
    localparam logic [1:0] XBUS_G0   = 2'd1;
    localparam logic [1:0] XBUS_G1   = 2'd2;

    // Grant state owned by master idx.
    function automatic logic [1:0] xbus_grant_state(input logic idx);
        return idx ? XBUS_G1 : XBUS_G0;
    endfunction

endpackage

// File: rtl/xbus_rr_pick.sv
// Combinational 2-way round-robin selector: on contention the master
// opposite to the previous owner wins.
module xbus_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    assign valid  = |req;
    assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/xbus_arbiter.sv
// Two-master round-robin arbiter for the internal data bus with locked bursts.
// Optional XBUS_LOCK_LIMIT_EN caps a locked burst at LOCK_MAX issues when contended.
module xbus_arbiter
    import xbus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = XBUS_ADDR_W,
    parameter int DATA_W   = XBUS_DATA_W,
    parameter int LOCK_MAX = XBUS_LOCK_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_sel,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata
);

    logic [1:0]        req;
    logic [1:0]        lock;
    logic [1:0]        we_in;
    logic [1:0]        gnt;
    logic [1:0]        issue;
    logic [1:0]        ack_reg;
    logic [ADDR_W-1:0] addr_in   [2];
    logic [DATA_W-1:0] wdata_in  [2];
    logic [DATA_W-1:0] rdata_out [2];

    logic [1:0] state_reg, state_next;
    logic       last_reg, last_next;
    logic       owner_reg, owner;
    logic       pick_winner, pick_valid;
    logic       cur, oth;
    logic       lock_hold, force_switch;

    assign req         = {m1_req, m0_req};
    assign lock        = {m1_lock, m0_lock};
    assign we_in       = {m1_we, m0_we};
    assign addr_in[0]  = m0_addr;
    assign addr_in[1]  = m1_addr;
    assign wdata_in[0] = m0_wdata;
    assign wdata_in[1] = m1_wdata;

    assign gnt    = {state_reg == XBUS_G1, state_reg == XBUS_G0};
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];
    assign issue  = req & gnt;

    // When nobody owns the bus, address/data stay on the previous owner to limit toggling.
    assign owner   = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : owner_reg);
    assign s_sel   = |issue;
    assign s_we    = |(issue & we_in);
    assign s_addr  = addr_in[owner];
    assign s_wdata = wdata_in[owner];

    assign cur       = (state_reg == XBUS_G1);
    assign oth       = ~cur;
    assign lock_hold = req[cur] & lock[cur];

    xbus_rr_pick u_pick (
        .req    (req),
        .last   (last_reg),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            XBUS_IDLE: begin
                if (pick_valid) state_next = xbus_grant_state(pick_winner);
            end
            XBUS_G0, XBUS_G1: begin
                if (lock_hold && !force_switch) begin
                    state_next = state_reg;
                end else if (req[oth]) begin
                    state_next = xbus_grant_state(oth);
                    last_next  = cur;
                end else if (req[cur]) begin
                    state_next = state_reg;
                end else begin
                    state_next = XBUS_IDLE;
                end
            end
            default: state_next = XBUS_IDLE;
        endcase
    end

`ifdef XBUS_LOCK_LIMIT_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LOCK_MAX);

    logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;

    assign force_switch = (state_reg != XBUS_IDLE) && (lock_cnt_reg == CNT_LAST) && req[oth];

    // Counts only consecutive locked holds; any other outcome restarts the run.
    always_comb begin
        lock_cnt_next = '0;
        if ((state_next == state_reg) && (state_reg != XBUS_IDLE) && lock_hold)
            lock_cnt_next = (lock_cnt_reg == CNT_SAT) ? lock_cnt_reg : lock_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lock_cnt_reg <= '0;
        else      lock_cnt_reg <= lock_cnt_next;
    end
`else
    logic lock_max_unused;
    assign lock_max_unused = (LOCK_MAX > 0);
    assign force_switch    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= XBUS_IDLE;
            last_reg  <= 1'b1;
            owner_reg <= 1'b0;
            ack_reg   <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            owner_reg <= owner;
            ack_reg   <= issue;
        end
    end

    // Read data is gated so a master only ever sees the bus on its own ack.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            assign rdata_out[gi] = ack_reg[gi] ? s_rdata : '0;
        end
    endgenerate

    assign m0_ack   = ack_reg[0];
    assign m1_ack   = ack_reg[1];
    assign m0_rdata = rdata_out[0];
    assign m1_rdata = rdata_out[1];

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed testbench for xbus_arbiter: round-robin, locked bursts, async reset, unused grants.
module tb_xbus_arbiter;

    localparam int AW          = 13;
    localparam int DW          = 32;
    localparam int TB_LOCK_MAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_ack;
    logic [DW-1:0] m1_rdata;
    logic          s_sel, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata = 32'hCAFE_0010;

    int n_chk  = 0;
    int n_pass = 0;

    xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(TB_LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
            $display("[%0t] ok   %s = %0h", $time, tag, got);
        end else begin
            $display("[%0t] FAIL %s: got %0h expected %0h", $time, tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        #3;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issue edge of the next cycle, then inputs settle one step later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_beats(input int n);
`ifdef XBUS_LOCK_LIMIT_EN
        return (n < TB_LOCK_MAX) ? n : TB_LOCK_MAX;
`else
        return n;
`endif
    endfunction

    // m1 locked write burst of n beats (lock dropped on the last) while m0 waits on a read.
    task automatic m1_burst(input string name, input int n, input logic [AW-1:0] base);
        int nb;
        nb = exp_beats(n);
        do_reset();
        next_cycle();
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = (n > 1); m1_addr = base; m1_wdata = 32'd1;
        #1;
        chk({name, "_c0_m1_gnt"}, {31'd0, m1_gnt}, 32'd0);
        for (int b = 0; b < nb; b++) begin
            next_cycle();
            m1_addr  = base + AW'(b);
            m1_wdata = DW'(b + 1);
            m1_lock  = (b < n - 1);
            m0_req   = 1'b1; m0_addr = 13'h040; m0_we = 1'b0;
            #1;
            chk($sformatf("%s_b%0d_m1_gnt", name, b), {31'd0, m1_gnt}, 32'd1);
            chk($sformatf("%s_b%0d_m0_gnt", name, b), {31'd0, m0_gnt}, 32'd0);
            chk($sformatf("%s_b%0d_s_we", name, b), {31'd0, s_we}, 32'd1);
            chk($sformatf("%s_b%0d_s_addr", name, b), 32'(s_addr), 32'(base) + b);
            chk($sformatf("%s_b%0d_s_wdata", name, b), s_wdata, b + 1);
        end
        next_cycle();
        if (nb < n) begin
            m1_addr = base + AW'(nb); m1_wdata = DW'(nb + 1); m1_lock = (nb < n - 1);
        end else begin
            m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
        end
        s_rdata = 32'h0B0B_0040;
        #1;
        chk({name, "_end_m0_gnt"}, {31'd0, m0_gnt}, 32'd1);
        chk({name, "_end_m1_gnt"}, {31'd0, m1_gnt}, 32'd0);
        chk({name, "_end_s_sel"}, {31'd0, s_sel}, 32'd1);
        chk({name, "_end_s_we"}, {31'd0, s_we}, 32'd0);
        chk({name, "_end_s_addr"}, 32'(s_addr), 32'h040);
        chk({name, "_end_m1_ack"}, {31'd0, m1_ack}, 32'd1);
        chk({name, "_end_m1_rdata"}, m1_rdata, 32'h0B0B_0040);
        next_cycle();
        idle_inputs();
        #1;
        chk({name, "_m0_ack"}, {31'd0, m0_ack}, 32'd1);
        chk({name, "_m1_ack_gone"}, {31'd0, m1_ack}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while rst is held low.
        #2;
        chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
        chk("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
        chk("rst_s_sel", {31'd0, s_sel}, 32'd0);
        chk("rst_s_we", {31'd0, s_we}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);

        // Single m0 read from IDLE.
        do_reset();
        next_cycle();
        m0_req = 1'b1; m0_addr = 13'h010; m0_we = 1'b0;
        #1;
        chk("t1_c0_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("t1_c0_s_sel", {31'd0, s_sel}, 32'd0);
        next_cycle();
        #1;
        chk("t1_c1_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("t1_c1_s_sel", {31'd0, s_sel}, 32'd1);
        chk("t1_c1_s_addr", 32'(s_addr), 32'h010);
        chk("t1_c1_s_we", {31'd0, s_we}, 32'd0);
        next_cycle();
        m0_req = 1'b0;
        #1;
        chk("t1_c2_m0_ack", {31'd0, m0_ack}, 32'd1);
        chk("t1_c2_m0_rdata", m0_rdata, 32'hCAFE_0010);
        chk("t1_c2_m1_rdata", m1_rdata, 32'd0);
        chk("t1_c2_s_sel", {31'd0, s_sel}, 32'd0);
        next_cycle();
        #1;
        chk("t1_c3_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("t1_c3_m0_ack", {31'd0, m0_ack}, 32'd0);
        chk("t1_c3_m0_rdata", m0_rdata, 32'd0);

        // Both request from IDLE: m0 first, then strict alternation.
        do_reset();
        next_cycle();
        m0_req = 1'b1; m0_addr = 13'h020;
        m1_req = 1'b1; m1_addr = 13'h030;
        #1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            #1;
            chk($sformatf("t2_i%0d_m0_gnt", i), {31'd0, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t2_i%0d_m1_gnt", i), {31'd0, m1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("t2_i%0d_s_addr", i), 32'(s_addr), (i % 2 == 0) ? 32'h020 : 32'h030);
            if (i > 0) begin
                chk($sformatf("t2_i%0d_m0_ack", i), {31'd0, m0_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
                chk($sformatf("t2_i%0d_m1_ack", i), {31'd0, m1_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            end
        end
        // m0 holds the grant for this cycle but no longer requests it.
        next_cycle();
        idle_inputs();
        #1;
        chk("t2_unused_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("t2_unused_s_sel", {31'd0, s_sel}, 32'd0);
        next_cycle();
        #1;
        chk("t2_idle_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("t2_idle_m0_ack", {31'd0, m0_ack}, 32'd0);

        // Locked bursts: 5 beats, then 10 beats against a waiting m0.
        m1_burst("t3", 5, 13'h100);
        m1_burst("t4", 10, 13'h200);

        // Asynchronous reset with an ack pending.
        do_reset();
        next_cycle();
        m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 13'h050;
        s_rdata = 32'hDEAD_0050;
        next_cycle();
        #1;
        chk("t5_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("t5_s_sel", {31'd0, s_sel}, 32'd1);
        next_cycle();
        #1;
        chk("t5_m0_ack", {31'd0, m0_ack}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_async_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        chk("t5_async_m0_ack", {31'd0, m0_ack}, 32'd0);
        chk("t5_async_s_sel", {31'd0, s_sel}, 32'd0);
        chk("t5_async_m0_rdata", m0_rdata, 32'd0);
        m1_req = 1'b1; m1_addr = 13'h060;
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        #1;
        chk("t5_rel_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("t5_rel_m1_gnt", {31'd0, m1_gnt}, 32'd0);

        // Grant unused: m1 drops req in its granted cycle while m0 starts requesting.
        do_reset();
        next_cycle();
        m1_req = 1'b1; m1_addr = 13'h070;
        #1;
        next_cycle();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_addr = 13'h080;
        #1;
        chk("t6_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        chk("t6_s_sel", {31'd0, s_sel}, 32'd0);
        next_cycle();
        #1;
        chk("t6_m1_ack", {31'd0, m1_ack}, 32'd0);
        chk("t6_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("t6_s_addr", 32'(s_addr), 32'h080);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xbus_arbiter.md
Name: xbus_arbiter

Overview:
Two-master arbiter for the picoVersat internal data bus (sel/we/addr/wdata/rdata) feeding the address decoder, xram data port, regf and peripherals.
- Master 0 is xctrl.
- Master 1 is a secondary engine, e.g. an object-table copier for vgadisplay or the external parallel port.
- Grants are round-robin with optional locked bursts; read data returns one cycle after issue, matching the synchronous xram/regf read.
- Sits between the masters and xaddr_decoder in xtop.

Parameters:
ADDR_W, 13, bus address width (matches `ADDR_W in xdefs.vh)
DATA_W, 32, bus data width (matches `DATA_W)
LOCK_MAX, 16, max consecutive locked cycles per grant (used only with XBUS_LOCK_LIMIT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
m0_req  in  1  master 0 access request
m0_lock  in  1  master 0 keeps grant after current access
m0_we  in  1  master 0 write enable
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_gnt  out  1  master 0 owns the bus this cycle
m0_ack  out  1  master 0 access completed (cycle after issue)
m0_rdata  out  DATA_W  master 0 read data, valid with m0_ack
m1_*  same set as m0_*, for master 1
s_sel  out  1  bus select to decoder
s_we  out  1  bus write enable
s_addr  out  ADDR_W  bus address
s_wdata  out  DATA_W  bus write data
s_rdata  in  DATA_W  decoder read mux output

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last=1, so master 0 wins first.
  - m0_gnt, m1_gnt, m0_ack, m1_ack, s_sel, s_we = 0.
  - Lock counter = 0.
  - A pending ack is dropped.
- States: IDLE, G0, G1. Gnt outputs are registered: m0_gnt=(state==G0), m1_gnt=(state==G1).
- Issue rule:
  - An access issues in any cycle with mX_req & mX_gnt.
  - s_sel=1 in that cycle; s_we, s_addr, s_wdata are muxed from the owner.
  - Otherwise s_sel=0, s_we=0, and s_addr/s_wdata come from the last owner.
  - The master updates req/addr on the clock edge where it observes its issue (valid/ready style).
- Ack:
  - mX_ack registered = issue_X.
  - mX_rdata = s_rdata while mX_ack=1, else 0.
  - Writes are acked identically.
- Transitions, evaluated each cycle:
  - IDLE: if both req, grant the master opposite to `last`; else the requester; else stay IDLE. IDLE -> G adds one cycle of latency.
  - GX with mX_req & mX_lock: stay GX (lock counter +1).
  - GX otherwise:
    - if the other master requests, go to G(other) and set last=X;
    - else if mX_req, stay GX (back-to-back, one access per cycle);
    - else IDLE.
  - GX with mX_req=0 (grant unused): same rules as above, no issue, no ack.
- Simultaneous events:
  - Lock held while the other master requests: the other waits, unbounded unless the optional feature is enabled.
  - Lock with req=0: lock is ignored.
- Lock counter clears on any grant change or on leaving GX.
- Never more than one gnt high; s_sel never high without an owner req.

Optional Feature:
XBUS_LOCK_LIMIT_EN
- Defined: the lock counter, saturating at LOCK_MAX, is active. When it reaches LOCK_MAX-1 and the other master requests, the arbiter switches to the other master on the next edge regardless of lock, and the counter clears.
- Undefined: the counter is not built and lock is honoured indefinitely.

Decomposition:
- Shared package/header xbus_defs.vh:
  - state encodings XBUS_IDLE=2'd0, XBUS_G0=2'd1, XBUS_G1=2'd2;
  - LOCK_MAX default;
  - includes xdefs.vh for widths.
- Natural sub-module: xbus_rr_pick, a combinational 2-way round-robin selector taking req[1:0] and last and returning the winner index and a valid bit.
- The top keeps the FSM, the muxes and the ack/rdata registers.

Test Plan:
- Reset release, m0_req=1 read addr 0x010 -> m0_gnt=1 at cycle 1, s_sel=1 with s_addr=0x010 at cycle 1, m0_ack=1 with m0_rdata=s_rdata at cycle 2.
- Both req from IDLE after reset -> G0 first; m0 single access, then G1 next cycle; accesses alternate 0,1,0,1 while both hold req.
- m1 burst: req+lock for 5 writes (0x100..0x104, data 1..5) while m0 requests -> five consecutive s_we pulses from m1, then m0_gnt on the following cycle.
- With XBUS_LOCK_LIMIT_EN, LOCK_MAX=4: m1 locked for 10 cycles, m0 requesting -> m1 gets exactly 4 issues, then m0 granted; without the macro m1 keeps all 10.
- rst=0 asynchronously mid-burst with m0_ack pending -> all gnt/ack/s_sel drop immediately with no clock edge; after release, first grant goes to m0.
- Grant unused: m1 granted, m1_req drops same cycle -> no s_sel, no m1_ack, FSM returns to IDLE (or to G0 if m0 requests).
